// File: rtl/div_unit.sv
// Multi-cycle RV32M divide/remainder unit: restoring radix-2 shift-subtract datapath
// sequenced by an IDLE/CALC/FIX/DONE FSM. DIV/REM by zero and signed overflow finish in one cycle.
module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start,
  input  logic [1:0]            Op,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  Flush,
  output logic                  Busy,
  output logic                  Valid,
  output logic [DATA_WIDTH-1:0] Result,
  output logic [1:0]            o_dbg_state
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

  // Handshake: Start/Op/SrcA/SrcB are taken only while Busy=0 (IDLE or DONE) and Flush=0;
  // the answer is presented on Result during the single cycle Valid=1 and held afterwards.
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t         r_state, w_state_nxt;
  logic           w_accept;
  logic [W-1:0]   r_dvd, r_dvs, r_rem, r_result;
  logic [CW-1:0]  r_cnt;
  logic           r_q_neg, r_r_neg, r_is_rem;

  logic           w_div0, w_ovf, w_special;
  logic [W-1:0]   w_special_res;
  logic           w_sa, w_sb;
  logic [W-1:0]   w_abs_a, w_abs_b;
  logic [W:0]     w_rem_sh;
  logic           w_ge;
  logic [W-1:0]   w_diff;
  logic [W-1:0]   w_q_fix, w_r_fix, w_fix_res;

  // Operand decode for the request being presented this cycle
  assign w_div0    = (SrcB == '0);
  assign w_ovf     = ~Op[0] && (SrcA == MIN_INT) && (SrcB == '1);
  assign w_special = w_div0 | w_ovf;
  assign w_sa      = ~Op[0] & SrcA[W-1];
  assign w_sb      = ~Op[0] & SrcB[W-1];
  assign w_abs_a   = w_sa ? ({W{1'b0}} - SrcA) : SrcA;
  assign w_abs_b   = w_sb ? ({W{1'b0}} - SrcB) : SrcB;

  always_comb begin
    w_special_res = '0;
    if (w_div0) w_special_res = Op[1] ? SrcA : '1;
    else        w_special_res = Op[1] ? '0 : MIN_INT;
  end

  // One restoring step: the remainder never reaches the divisor, so W bits hold the difference
  assign w_rem_sh = {r_rem, r_dvd[W-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
  assign w_diff   = w_rem_sh[W-1:0] - r_dvs;

  assign w_q_fix   = r_q_neg ? ({W{1'b0}} - r_dvd) : r_dvd;
  assign w_r_fix   = r_r_neg ? ({W{1'b0}} - r_rem) : r_rem;
  assign w_fix_res = r_is_rem ? w_r_fix : w_q_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (Flush) begin
          w_state_nxt = S_IDLE;
        end else if (Start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_special ? S_DONE : S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (Flush)                           w_state_nxt = S_IDLE;
        else if (r_cnt == CW'(DATA_WIDTH-1)) w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = Flush ? S_IDLE : S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign Busy        = (r_state == S_CALC) || (r_state == S_FIX);
  assign Valid       = (r_state == S_DONE);
  assign Result      = r_result;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_is_rem <= 1'b0;
    end else if (w_accept) begin
      if (w_special) begin
        r_result <= w_special_res;
      end else begin
        r_dvd    <= w_abs_a;
        r_dvs    <= w_abs_b;
        r_rem    <= '0;
        r_cnt    <= '0;
        r_q_neg  <= w_sa ^ w_sb;
        r_r_neg  <= w_sa;
        r_is_rem <= Op[1];
      end
    end else if (r_state == S_CALC && !Flush) begin
      // Quotient bits shift into the vacated dividend LSBs
      r_dvd <= {r_dvd[W-2:0], w_ge};
      r_rem <= w_ge ? w_diff : w_rem_sh[W-1:0];
      r_cnt <= r_cnt + CW'(1);
    end else if (r_state == S_FIX && !Flush) begin
      r_result <= w_fix_res;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: a latency-window model with RISC-V M arithmetic predicts Busy/Valid/Result
// every cycle, while directed operations pin that model with hand-computed results and latencies.
module tb_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         Start = 1'b0;
  logic         Flush = 1'b0;
  logic [1:0]   Op = 2'd0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         Busy, Valid;
  logic [W-1:0] Result;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .Flush(Flush), .Busy(Busy), .Valid(Valid), .Result(Result), .o_dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V M results, including divide-by-zero and signed overflow
  function automatic logic [W-1:0] ref_div(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == '0) return op[1] ? a : '1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? '0 : a;
    case (op)
      2'd0:    return sa / sb;
      2'd1:    return a / b;
      2'd2:    return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic logic is_special(input logic [1:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
    return (b == '0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Model: an accepted normal op is busy for W+1 cycles, then valid for one; specials are valid next cycle
  logic         exp_busy, exp_valid;
  logic [W-1:0] exp_result;
  int           m_cnt;
  logic [W-1:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_busy   <= 1'b0;
      exp_valid  <= 1'b0;
      exp_result <= '0;
      m_cnt      <= 0;
      exp_q.delete();
    end else if (Flush) begin
      exp_busy  <= 1'b0;
      exp_valid <= 1'b0;
      m_cnt     <= 0;
      exp_q.delete();
    end else if (!exp_busy && Start) begin
      if (is_special(Op, SrcA, SrcB)) begin
        exp_result <= ref_div(Op, SrcA, SrcB);
        exp_valid  <= 1'b1;
      end else begin
        exp_q.push_back(ref_div(Op, SrcA, SrcB));
        exp_busy  <= 1'b1;
        exp_valid <= 1'b0;
        m_cnt     <= W + 1;
      end
    end else if (exp_busy) begin
      if (m_cnt == 1) begin
        exp_busy   <= 1'b0;
        exp_valid  <= 1'b1;
        exp_result <= exp_q.pop_front();
        m_cnt      <= 0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else begin
      exp_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", {31'b0, Busy}, {31'b0, exp_busy});
      chk("valid", {31'b0, Valid}, {31'b0, exp_valid});
      chk("result", Result, exp_result);
    end
  end

  // Presents a request for one cycle; returns #1 after the sampling edge
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Op    = op;
    SrcA  = a;
    SrcB  = b;
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic wait_valid(input string name, input logic [W-1:0] exp, input int lat);
    int n;
    n = 1;
    while (!Valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_valid"}, {31'b0, Valid}, 32'd1);
    chk({name, "_lat"}, n, lat);
    chk(name, Result, exp);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    @(posedge clk);
    #1;
    issue(op, a, b);
    wait_valid(name, exp, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_valid", {31'b0, Valid}, 32'd0);
    chk("rst_result", Result, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, 32'd0);

    run_op("divu_100_7", 2'd1, 32'd100, 32'd7, 32'd14, 34);
    issue(2'd3, 32'd100, 32'd7);
    wait_valid("remu_100_7_in_done", 32'd2, 34);
    run_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("rem_7_m2", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    run_op("div_7_m2", 2'd0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    run_op("div_5_0", 2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    issue(2'd3, 32'd5, 32'd0);
    wait_valid("remu_5_0_in_done", 32'd5, 1);
    run_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("divu_min_allones", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
    run_op("div_min_3", 2'd0, 32'h8000_0000, 32'd3, 32'hD555_5556, 34);
    run_op("rem_min_3", 2'd2, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 34);
    run_op("remu_max_10", 2'd3, 32'hFFFF_FFFF, 32'd10, 32'd5, 34);
    run_op("divu_max_1", 2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
    run_op("div_0_5", 2'd0, 32'd0, 32'd5, 32'd0, 34);
    run_op("div_m1_m1", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 34);

    // Flush mid-CALC: no Valid, Result keeps the previous answer, then a fresh op runs normally
    @(posedge clk);
    #1;
    issue(2'd1, 32'd1000, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    Flush = 1'b1;
    @(posedge clk);
    #1;
    Flush = 1'b0;
    chk("flush_busy", {31'b0, Busy}, 32'd0);
    chk("flush_valid", {31'b0, Valid}, 32'd0);
    chk("flush_result_kept", Result, 32'd1);
    @(posedge clk);
    #1;
    issue(2'd1, 32'd9, 32'd3);
    wait_valid("divu_9_3_after_flush", 32'd3, 34);

    // Flush and Start together in IDLE: the request is dropped
    @(posedge clk);
    #1;
    Flush = 1'b1;
    issue(2'd0, 32'd5, 32'd0);
    Flush = 1'b0;
    chk("flush_start_valid", {31'b0, Valid}, 32'd0);
    chk("flush_start_busy", {31'b0, Busy}, 32'd0);

    // Start held high in cycles 5-15 of an op is ignored
    @(posedge clk);
    #1;
    issue(2'd1, 32'd100, 32'd7);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    Op    = 2'd0;
    SrcA  = 32'd55;
    SrcB  = 32'd0;
    Start = 1'b1;
    repeat (11) begin
      @(posedge clk);
      #1;
    end
    Start = 1'b0;
    wait_valid("divu_ignored_starts", 32'd14, 19);

    // Asynchronous reset in the middle of CALC
    @(posedge clk);
    #1;
    issue(2'd1, 32'd100, 32'd7);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", {31'b0, Busy}, 32'd0);
    chk("midreset_valid", {31'b0, Valid}, 32'd0);
    chk("midreset_result", Result, 32'd0);
    chk("midreset_state", {30'b0, dbg_state}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op("divu_after_reset", 2'd1, 32'd100, 32'd7, 32'd14, 34);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
